word_splitter: RTL and testbench

Byte-serial transmitter for 16-bit instruction/data words. Accepts a 16-bit word over a valid/ready handshake and drives it onto the 8-bit byte bus as high byte then low byte on two consecutive clk1 cycles, with ena held high for both. This is the sending end of the two-phase byte protocol used by the instruction register: that receiver keeps no backpressure and clears its phase whenever ena drops, so the pair must never be split. Also drives a byte address that advances once per emitted byte, for ROM/RAM image loaders and the test harness.

---
 rtl/word_splitter_if.sv | 33 +++
 rtl/word_splitter.sv | 141 ++++++++++++++
 tb/tb_word_splitter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_splitter_if.sv
// Word handshake and byte-bus bundle between a word source and word_splitter.
// The master side offers words and observes the emitted byte stream.
interface word_splitter_if #(
  parameter int ADDR_W = 13
) ();
  logic              in_valid;
  logic [15:0]       in_word;
  logic              in_ready;
  logic              ena;
  logic [7:0]        data;
  logic [ADDR_W-1:0] addr;
  logic              phase;

  modport master (
    output in_valid,
    output in_word,
    input  in_ready,
    input  ena,
    input  data,
    input  addr,
    input  phase
  );

  modport slave (
    input  in_valid,
    input  in_word,
    output in_ready,
    output ena,
    output data,
    output addr,
    output phase
  );
endinterface

// File: rtl/word_splitter.sv
// Sends each accepted 16-bit word as a high/low byte pair on consecutive cycles,
// with a one-word pending buffer so a stream of words flows without bubbles.
module word_splitter #(
  parameter int ADDR_W = 13
) (
  input  logic              clk1,
  input  logic              rst,
  word_splitter_if.slave    bus,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              busy,
  output logic [7:0]        word_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       sreg_q, sreg_d;
  logic [15:0]       pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic              ena_q, ena_d;
  logic [7:0]        data_q, data_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              accept_s;
  logic              load_ok_s;

  assign accept_s  = bus.in_valid && !pend_v_q;
  assign load_ok_s = addr_load && (state_q == S_IDLE) && !pend_v_q;

  // Next-state, buffering and registered-output computation.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          sreg_d  = bus.in_word;
          state_d = S_HI;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HI: begin
        state_d = S_LO;
        if (accept_s) begin
          pend_d   = bus.in_word;
          pend_v_d = 1'b1;
        end else begin
          pend_v_d = pend_v_q;
        end
      end
      S_LO: begin
        cnt_d = cnt_q + 8'd1;
        // A buffered word takes priority; the port is closed while it waits.
        if (pend_v_q) begin
          sreg_d   = pend_q;
          pend_v_d = 1'b0;
          state_d  = S_HI;
        end else if (accept_s) begin
          sreg_d  = bus.in_word;
          state_d = S_HI;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        pend_v_d = 1'b0;
      end
    endcase

    case (state_d)
      S_HI: begin
        ena_d   = 1'b1;
        data_d  = sreg_d[15:8];
        phase_d = 1'b0;
      end
      S_LO: begin
        ena_d   = 1'b1;
        data_d  = sreg_d[7:0];
        phase_d = 1'b1;
      end
      default: begin
        ena_d   = 1'b0;
        data_d  = 8'h00;
        phase_d = 1'b0;
      end
    endcase

    if (load_ok_s) begin
      addr_d = addr_base;
    end else if (ena_q) begin
      addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      addr_d = addr_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sreg_q   <= 16'h0000;
      pend_q   <= 16'h0000;
      pend_v_q <= 1'b0;
      ena_q    <= 1'b0;
      data_q   <= 8'h00;
      phase_q  <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      cnt_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ena_q    <= ena_d;
      data_q   <= data_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready = !pend_v_q;
  assign bus.ena      = ena_q;
  assign bus.data     = data_q;
  assign bus.phase    = phase_q;
  assign bus.addr     = addr_q;
  assign busy         = (state_q != S_IDLE) || pend_v_q;
  assign word_cnt     = cnt_q;

endmodule

// File: tb/tb_word_splitter.sv
// Scoreboard bench for word_splitter: the driver predicts every byte from the
// accepted words; a negedge monitor pops and compares whenever ena is high.
module tb_word_splitter;
  localparam int AW = 13;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          addr_load;
  logic [AW-1:0] addr_base;
  logic          busy;
  logic [7:0]    word_cnt;

  word_splitter_if #(.ADDR_W(AW)) bus ();

  word_splitter #(.ADDR_W(AW)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .bus       (bus),
    .addr_load (addr_load),
    .addr_base (addr_base),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed {
    logic [7:0]    d;
    logic [AW-1:0] a;
    logic          p;
    logic [7:0]    c;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [15:0]   rx_q[$];
  logic [7:0]    rcv_hi;
  bit            rcv_ph;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [AW-1:0] ref_addr;
  logic [7:0]    ref_cnt;
  bit            idle_known;
  int            run_len = 0;
  int            last_run = 0;
  int            gap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every byte cycle must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk1);
      if (rst !== 1'b0) begin
        run_len = 0;
      end else if (bus.ena === 1'b1) begin
        run_len++;
        chk("busy_during_byte", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: data %02h at addr %0h, none expected", bus.data, bus.addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("byte_data",  {24'd0, bus.data},  {24'd0, mon_e.d});
          chk("byte_addr",  {19'd0, bus.addr},  {19'd0, mon_e.a});
          chk("byte_phase", {31'd0, bus.phase}, {31'd0, mon_e.p});
          chk("word_cnt_during_byte", {24'd0, word_cnt}, {24'd0, mon_e.c});
        end
      end else begin
        if (run_len != 0) begin
          chk("ena_run_even", 32'(run_len % 2), 32'd0);
          last_run = run_len;
          run_len  = 0;
        end
        chk("idle_data",  {24'd0, bus.data},  32'd0);
        chk("idle_phase", {31'd0, bus.phase}, 32'd0);
      end
    end
  end

  // Reference instruction-register receiver: pairs bytes, loses phase when ena drops.
  initial begin
    rcv_ph = 1'b0;
    rcv_hi = 8'h00;
    forever begin
      @(negedge clk1);
      if (rst !== 1'b0) begin
        rcv_ph = 1'b0;
      end else if (bus.ena === 1'b1) begin
        if (!rcv_ph) begin
          rcv_hi = bus.data;
          rcv_ph = 1'b1;
        end else begin
          rx_q.push_back({rcv_hi, bus.data});
          rcv_ph = 1'b0;
        end
      end else begin
        rcv_ph = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic stop_in();
    @(posedge clk1); #1;
    bus.in_valid = 1'b0;
    addr_load    = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit load, input logic [AW-1:0] base);
    bit done = 1'b0;
    @(posedge clk1); #1;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    addr_load    = load;
    addr_base    = base;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk1);
      if (bus.in_ready === 1'b1) begin
        if (load && idle_known) ref_addr = base;
        exp_q.push_back('{d: w[15:8], a: ref_addr, p: 1'b0, c: ref_cnt});
        ref_addr = ref_addr + 13'd1;
        exp_q.push_back('{d: w[7:0], a: ref_addr, p: 1'b1, c: ref_cnt});
        ref_addr   = ref_addr + 13'd1;
        ref_cnt    = ref_cnt + 8'd1;
        idle_known = 1'b0;
        done       = 1'b1;
      end else begin
        @(posedge clk1); #1;
        addr_load = 1'b0;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: word %04h never accepted", w);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    stop_in();
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk1); #1;
      if (exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d bytes never emitted", exp_q.size());
      exp_q.delete();
    end
    idle_known = 1'b1;
  endtask

  task automatic check_idle(input int exp_run);
    @(posedge clk1); #1;
    chk("idle_addr",     {19'd0, bus.addr},     {19'd0, ref_addr});
    chk("idle_word_cnt", {24'd0, word_cnt},     {24'd0, ref_cnt});
    chk("idle_busy",     {31'd0, busy},         32'd0);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("idle_ena",      {31'd0, bus.ena},      32'd0);
    @(negedge clk1); #1;
    if (exp_run >= 0) chk("ena_run_len", 32'(last_run), 32'(exp_run));
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_word  = 16'h0000;
    addr_load    = 1'b0;
    addr_base    = 13'h0000;
    ref_addr     = 13'h0000;
    ref_cnt      = 8'h00;
    idle_known   = 1'b1;

    repeat (3) @(posedge clk1);
    #1;
    chk("rst_ena",      {31'd0, bus.ena},   32'd0);
    chk("rst_data",     {24'd0, bus.data},  32'd0);
    chk("rst_phase",    {31'd0, bus.phase}, 32'd0);
    chk("rst_addr",     {19'd0, bus.addr},  32'd0);
    chk("rst_word_cnt", {24'd0, word_cnt},  32'd0);
    chk("rst_busy",     {31'd0, busy},      32'd0);
    rst = 1'b0;
    @(posedge clk1); #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single word with a base address load.
    send_word(16'hA55A, 1'b1, 13'h0100);
    drain();
    check_idle(2);

    // Back-to-back stream must fill six consecutive byte cycles.
    send_word(16'h1234, 1'b0, 13'h0000);
    send_word(16'h5678, 1'b0, 13'h0000);
    send_word(16'h9ABC, 1'b0, 13'h0000);
    drain();
    check_idle(6);

    // Address wrap across the top of the byte space.
    send_word(16'hBEEF, 1'b1, 13'h1FFF);
    drain();
    check_idle(2);

    // addr_load during the high-byte cycle is ignored.
    send_word(16'h0F0F, 1'b0, 13'h0000);
    @(posedge clk1); #1;
    bus.in_valid = 1'b0;
    addr_load    = 1'b1;
    addr_base    = 13'h0000;
    @(posedge clk1); #1;
    addr_load = 1'b0;
    drain();
    check_idle(2);

    // Loopback through the reference receiver.
    rx_q.delete();
    send_word(16'h7E81, 1'b0, 13'h0000);
    send_word(16'h0001, 1'b0, 13'h0000);
    drain();
    check_idle(4);
    chk("loop_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      chk("loop_word0", {16'd0, rx_q[0]}, 32'h7E81);
      chk("loop_word1", {16'd0, rx_q[1]}, 32'h0001);
    end

    // Random words with random gaps and occasional idle-time address loads.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        drain();
        send_word(16'($urandom), 1'b1, AW'($urandom));
      end else begin
        send_word(16'($urandom), 1'b0, 13'h0000);
      end
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        stop_in();
        repeat (gap - 1) @(posedge clk1);
      end
    end
    drain();
    check_idle(-1);

    // Reset during the high byte while another word is offered.
    send_word(16'hCAFE, 1'b0, 13'h0000);
    @(posedge clk1); #1;
    rst         = 1'b1;
    bus.in_word = 16'h1111;
    @(posedge clk1); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    ref_addr   = 13'h0000;
    ref_cnt    = 8'h00;
    idle_known = 1'b1;
    chk("midrst_ena",      {31'd0, bus.ena},      32'd0);
    chk("midrst_data",     {24'd0, bus.data},     32'd0);
    chk("midrst_addr",     {19'd0, bus.addr},     32'd0);
    chk("midrst_word_cnt", {24'd0, word_cnt},     32'd0);
    chk("midrst_busy",     {31'd0, busy},         32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (4) @(posedge clk1);
    #1;

    // Normal operation resumes after the abort.
    send_word(16'h1357, 1'b1, 13'h0AAA);
    drain();
    check_idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
